// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
//
// Read-side consumer stage of the async FIFO. It runs in the read clock domain. It turns
// the FIFO pop interface (rempty/rinc with one-cycle-latency rdata) into a registered
// valid/ready stream.
//
// A 2-entry buffer absorbs the memory read latency. It also tracks the one pop that may
// still be in flight. The stream can therefore sustain 1 word/cycle with no drops or
// duplicates under back-pressure.
//
// Optional feature: define RD_ADAPT_CNT_EN to add rd_word_cnt, a saturating 16-bit count
// of stream transfers.
//
// Ports:
//   rclk        read-domain clock
//   rrst_n      asynchronous active-low reset
//   rempty      FIFO empty flag (1 while in reset)
//   rinc        pop request to the read pointer logic
//   rdata       memory read data, valid the cycle after the pop
//   m_valid     stream word valid
//   m_ready     downstream accept
//   m_data      stream word (driven from buffer registers)
//   rd_word_cnt transfer count, present only with RD_ADAPT_CNT_EN
module fifo_rd_stream_adapter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              rempty,
  output logic              rinc,
  input  logic [DATA_W-1:0] rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef RD_ADAPT_CNT_EN
  ,
  output logic [15:0]       rd_word_cnt
`endif
);

  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;

  logic              xfer;
  logic [2:0]        level;

  // Outputs come straight from state; m_data is a mux of registered entries.
  always_comb begin
    m_valid = (occ_q != 2'd0);
    m_data  = head_q ? buf1_q : buf0_q;
  end

  // Level after this edge: buffered words plus the word landing now, minus the one leaving.
  // xfer implies occ_q >= 1, so the subtraction cannot wrap.
  always_comb begin
    xfer  = m_valid && m_ready;
    level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};
    // Only pop when the word will have a free slot on arrival.
    rinc  = !rempty && (level < 3'd2);
  end

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = level[1:0];
    inflight_d = rinc;
    if (inflight_q) begin
      if (tail_q) begin
        buf1_d = rdata;
      end else begin
        buf0_d = rdata;
      end
      tail_d = ~tail_q;
    end
    if (xfer) begin
      head_d = ~head_q;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef RD_ADAPT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Testbench for fifo_rd_stream_adapter: FIFO model plus per-cycle directed vectors.
module tb_fifo_rd_stream_adapter;

  logic       rclk;
  logic       rrst_n;
  logic       rempty;
  logic       rinc;
  logic [7:0] rdata;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef RD_ADAPT_CNT_EN
  logic [15:0] rd_word_cnt;
`endif

  int tests;
  int fails;

  fifo_rd_stream_adapter #(
    .DATA_W(8)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rinc    (rinc),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef RD_ADAPT_CNT_EN
    ,
    .rd_word_cnt (rd_word_cnt)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // FIFO model: words are pushed by the stimulus, and a pop returns a word the next cycle.
  // Reset discards the stored words.
  logic [7:0] mem [0:255];
  int wr_ptr;
  int rd_ptr;

  assign rempty = !rrst_n || (wr_ptr == rd_ptr);

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_ptr <= wr_ptr;
    end else if (rinc) begin
      rdata  <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  typedef struct {
    string      name;
    int         npush;
    logic [7:0] base;
    logic       rdy;
    logic       e_rinc;
    logic       e_valid;
    logic       chk_data;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input int npush, input logic [7:0] base,
                              input logic rdy, input logic e_rinc, input logic e_valid,
                              input logic chk_data, input logic [7:0] e_data);
    vec_t v;
    v.name = name; v.npush = npush; v.base = base; v.rdy = rdy;
    v.e_rinc = e_rinc; v.e_valid = e_valid; v.chk_data = chk_data; v.e_data = e_data;
    vecs.push_back(v);
  endfunction

  task automatic push_words(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      mem[wr_ptr[7:0]] = base + 8'(k);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic check(input string name, input logic e_rinc, input logic e_valid,
                       input logic chk_data, input logic [7:0] e_data);
    tests++;
    if (rinc !== e_rinc || m_valid !== e_valid || (chk_data && m_data !== e_data)) begin
      fails++;
      $display("FAIL %s: got rinc=%b m_valid=%b m_data=%h, want rinc=%b m_valid=%b m_data=%h",
               name, rinc, m_valid, m_data, e_rinc, e_valid,
               chk_data ? e_data : m_data);
    end
  endtask

  // One vector per cycle: apply at the falling edge, then compare 1 time unit later.
  task automatic run_vecs();
    foreach (vecs[i]) begin
      @(negedge rclk);
      push_words(vecs[i].npush, vecs[i].base);
      m_ready = vecs[i].rdy;
      #1;
      check(vecs[i].name, vecs[i].e_rinc, vecs[i].e_valid, vecs[i].chk_data, vecs[i].e_data);
    end
    vecs.delete();
  endtask

`ifdef RD_ADAPT_CNT_EN
  task automatic check_cnt(input string name, input logic [15:0] exp);
    tests++;
    if (rd_word_cnt !== exp) begin
      fails++;
      $display("FAIL %s: got rd_word_cnt=%h, want %h", name, rd_word_cnt, exp);
    end
  endtask
`endif

  initial begin
    tests   = 0;
    fails   = 0;
    wr_ptr  = 0;
    rd_ptr  = 0;
    rdata   = 8'h00;
    m_ready = 1'b0;
    rrst_n  = 1'b0;

    // Reset
    repeat (3) @(posedge rclk);
    #1;
    check("in_reset", 1'b0, 1'b0, 1'b1, 8'h00);
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int k = 0; k < 3; k++) add("post_reset_idle", 0, 8'h00, 1'b0, 0, 0, 1, 8'h00);

    // Single word
    add("single_T",  1, 8'hA5, 1'b1, 1, 0, 1, 8'h00);
    add("single_T1", 0, 8'h00, 1'b1, 0, 0, 1, 8'h00);
    add("single_T2", 0, 8'h00, 1'b1, 0, 1, 1, 8'hA5);
    add("single_T3", 0, 8'h00, 1'b1, 0, 0, 0, 8'h00);
    add("single_T4", 0, 8'h00, 1'b1, 0, 0, 0, 8'h00);

    // Back-pressure: two pops then stall, then drain with no bubble
    add("bp_pop0",  4, 8'h01, 1'b0, 1, 0, 0, 8'h00);
    add("bp_pop1",  0, 8'h00, 1'b0, 1, 0, 0, 8'h00);
    add("bp_hold0", 0, 8'h00, 1'b0, 0, 1, 1, 8'h01);
    add("bp_full0", 0, 8'h00, 1'b0, 0, 1, 1, 8'h01);
    add("bp_full1", 0, 8'h00, 1'b0, 0, 1, 1, 8'h01);
    add("bp_drain1", 0, 8'h00, 1'b1, 1, 1, 1, 8'h01);
    add("bp_drain2", 0, 8'h00, 1'b1, 1, 1, 1, 8'h02);
    add("bp_drain3", 0, 8'h00, 1'b1, 0, 1, 1, 8'h03);
    add("bp_drain4", 0, 8'h00, 1'b1, 0, 1, 1, 8'h04);
    add("bp_done",   0, 8'h00, 1'b1, 0, 0, 0, 8'h00);

    // Streaming: 8 words at full rate
    add("st_S0", 8, 8'h10, 1'b1, 1, 0, 0, 8'h00);
    add("st_S1", 0, 8'h00, 1'b1, 1, 0, 0, 8'h00);
    for (int k = 0; k < 6; k++) add("st_run", 0, 8'h00, 1'b1, 1, 1, 1, 8'h10 + 8'(k));
    add("st_S8",  0, 8'h00, 1'b1, 0, 1, 1, 8'h16);
    add("st_S9",  0, 8'h00, 1'b1, 0, 1, 1, 8'h17);
    add("st_S10", 0, 8'h00, 1'b1, 0, 0, 0, 8'h00);

    // Reset mid-operation: build up occ=1 with a pop in flight
    add("rst_pop0", 4, 8'h40, 1'b0, 1, 0, 0, 8'h00);
    add("rst_pop1", 0, 8'h00, 1'b0, 1, 0, 0, 8'h00);
    run_vecs();

    @(negedge rclk);
    #1;
    check("rst_before", 1'b0, 1'b1, 1'b1, 8'h40);
    #1;
    rrst_n = 1'b0;
    #1;
    check("rst_async", 1'b0, 1'b0, 1'b1, 8'h00);
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int k = 0; k < 4; k++) add("rst_after", 0, 8'h00, 1'b1, 0, 0, 1, 8'h00);
    run_vecs();

`ifdef RD_ADAPT_CNT_EN
    check_cnt("cnt_after_reset", 16'd0);
    @(negedge rclk);
    m_ready = 1'b1;
    push_words(5, 8'h60);
    repeat (10) @(negedge rclk);
    #1;
    check_cnt("cnt_five", 16'd5);
    m_ready = 1'b0;
    force dut.cnt_q = 16'hFFFE;
    @(posedge rclk);
    #1;
    release dut.cnt_q;
    @(negedge rclk);
    check_cnt("cnt_preload", 16'hFFFE);
    m_ready = 1'b1;
    push_words(3, 8'h70);
    repeat (8) @(negedge rclk);
    #1;
    check_cnt("cnt_saturate", 16'hFFFF);
    rrst_n = 1'b0;
    #1;
    check_cnt("cnt_reset", 16'd0);
    @(negedge rclk);
    rrst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
